fc_neuron_stream: RTL and testbench
===================================

Name: fc_neuron_stream

Overview:
- Sequential, parametrised successor of the fully-parallel fully-connected neuron layer.
- Computes z = act(bias + sum over i of x[i]*w[i]) for one neuron, for a frame of IN signed inputs.
- Takes LANES input/weight pairs per accepted beat and holds a registered result behind a valid/ready handshake.
- Sits between the feature buffer (upstream) and the next layer or argmax (downstream); one instance per neuron or time-multiplexed across neurons.

Parameters:
- WIDTH, 8, signed bit width of each x and w element.
- IN, 400, inputs per frame (>=1).
- LANES, 4, x/w pairs consumed per beat (1..IN); IN need not be a multiple of LANES.
- RELU_EN, 1, 1 = ReLU on output; 0 = pass the signed sum through.
- ACC_W, 2*WIDTH+$clog2(IN)+1, accumulator and output width (localparam-derived default; the +1 absorbs the bias).

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, 1, beat of x/w pairs presented.
- in_ready, out, 1, block accepts a beat this cycle.
- x, in, LANES*WIDTH, packed signed inputs; lane k is bits [k*WIDTH +: WIDTH].
- w, in, LANES*WIDTH, packed signed weights, same lane layout.
- bias, in, 2*WIDTH, signed bias; sampled on the first beat of each frame.
- out_valid, out, 1, z holds a finished result.
- out_ready, in, 1, downstream consumes z.
- z, out, ACC_W, result (signed, or non-negative when RELU_EN=1).
- busy, out, 1, a frame is partially accumulated.

Behaviour:
- BEATS = ceil(IN/LANES); TAIL = IN - (BEATS-1)*LANES.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (rst_n=0 at a clock edge, any state including mid-frame):
  - state=ACC, beat_cnt=0, acc=0, z=0, out_valid=0, busy=0.
  - Any partial frame is discarded.
- Beat accepted when in_valid && in_ready.
- dot = signed sum of the LANES products x[k]*w[k], combinational, full width.
  - On the last beat (beat_cnt==BEATS-1), lanes k>=TAIL contribute 0 regardless of their x/w.
- First beat (beat_cnt==0): acc <= sext(bias) + dot; busy <= 1.
- Other beats: acc <= acc + dot.
- Last beat (including BEATS==1, where it is also the first beat):
  - z <= act(final sum); state <= HOLD; out_valid <= 1 on the next cycle; beat_cnt <= 0; busy <= 0.
- Latency: z is valid one cycle after the last beat. Throughput is BEATS+1 cycles per frame when out_ready is held high.
- act:
  - RELU_EN=1: z = sum MSB ? 0 : sum.
  - RELU_EN=0: z = sum.
- HOLD:
  - z and out_valid stay stable until out_valid && out_ready.
  - On that handshake: state <= ACC, out_valid <= 0.
  - in_valid is ignored while in HOLD.
- Idle in_valid=0 mid-frame: acc and beat_cnt hold; there is no timeout.
- All arithmetic is two's-complement signed with sign extension to ACC_W. There is no saturation; ACC_W is sized so that overflow cannot occur.

Decomposition:
- Package fc_pkg holds:
  - state enum fc_state_t {ACC, HOLD};
  - function beats(IN, LANES);
  - function tail(IN, LANES).
- Sub-module fc_lane_dot: combinational, parameters WIDTH/LANES/ACC_W, inputs x, w and a lane_mask[LANES] vector, output dot. It contains the products and a balanced adder tree with per-level width growth.
- fc_neuron_stream owns the FSM, beat counter, accumulator, activation and output register.

Test Plan:
- Reset and single frame (IN=10, LANES=4, BEATS=3, TAIL=2):
  - Stimulus: bias=5, all x=1, w=2 on every lane, garbage x=127, w=127 in masked lanes 2..3 of beat 3, out_ready=1.
  - Required: z=25, out_valid exactly 1 cycle after beat 3.
- ReLU clamp:
  - Stimulus: same frame with w=-2, bias=0.
  - Required: RELU_EN=1 gives z=0; RELU_EN=0 gives z=-20 in ACC_W two's complement.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid; drive in_valid=1 with new data meanwhile.
  - Required: in_ready=0, z stable, no beat consumed. After out_ready=1, the next frame starts cleanly from the bias.
- Extreme values (IN=400, LANES=4):
  - Stimulus: all x=-128, w=-128, bias=32767.
  - Required: z = 400*16384 + 32767 = 6586367, with no overflow.
- Mid-frame reset and stalls:
  - Stimulus: assert rst_n=0 after beat 2 of 3, then run a full frame with x=3, w=1, bias=0.
  - Required: z=30, with no residue from the aborted frame.
  - Random in_valid gaps inside a frame do not change z.
- Degenerate sizes:
  - IN=1, LANES=1: x=-7, w=3, bias=1 gives z=0 (ReLU) and out_valid 1 cycle after the single beat.
  - IN=LANES=8: one beat per frame.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared state type and frame geometry helpers for the streaming neuron
package fc_pkg;
  typedef enum logic {ACC, HOLD} fc_state_t;
  function automatic int beats(int n, int l);
    return (n + l - 1) / l;
  endfunction
  function automatic int tail(int n, int l);
    return n - (beats(n, l) - 1) * l;
  endfunction
endpackage

// File: rtl/fc_neuron_stream_if.sv
// fc_neuron_stream_if: input beat and result handshakes of the streaming neuron
interface fc_neuron_stream_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 26
);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [LANES*WIDTH-1:0] x, w;
  logic signed [2*WIDTH-1:0] bias;
  logic signed [ACC_W-1:0] z;
  modport master(output in_valid, x, w, bias, out_ready, input in_ready, out_valid, z, busy);
  modport slave(input in_valid, x, w, bias, out_ready, output in_ready, out_valid, z, busy);
endinterface

// File: rtl/fc_lane_dot.sv
// fc_lane_dot: masked per-lane products summed by a balanced tree that widens by one bit per level
module fc_lane_dot #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 26
) (
  input  logic [LANES*WIDTH-1:0] x,
  input  logic [LANES*WIDTH-1:0] w,
  input  logic [LANES-1:0]       lane_mask,
  output logic signed [ACC_W-1:0] dot
);
  localparam int L = $clog2(LANES);
  localparam int P = 1 << L;
  genvar l, i;
  for (l = 0; l <= L; l++) begin : lv
    logic signed [2*WIDTH+l-1:0] s [P>>l];
    for (i = 0; i < (P >> l); i++) begin : n
      if (l == 0) begin : leaf
        if (i < LANES) begin : used
          logic signed [2*WIDTH-1:0] xe, we;
          assign xe = {{WIDTH{x[i*WIDTH+WIDTH-1]}}, x[i*WIDTH +: WIDTH]};
          assign we = {{WIDTH{w[i*WIDTH+WIDTH-1]}}, w[i*WIDTH +: WIDTH]};
          assign s[i] = lane_mask[i] ? xe * we : '0;
        end else begin : pad
          assign s[i] = '0;
        end
      end else begin : node
        logic signed [2*WIDTH+l-2:0] a, b;
        assign a = lv[l-1].s[2*i];
        assign b = lv[l-1].s[2*i+1];
        assign s[i] = {a[2*WIDTH+l-2], a} + {b[2*WIDTH+l-2], b};
      end
    end
  end
  assign dot = ACC_W'(lv[L].s[0]);
endmodule

// File: rtl/fc_neuron_stream.sv
// fc_neuron_stream: accumulates LANES x*w pairs per beat into bias + dot, then holds act(sum) for downstream
module fc_neuron_stream
  import fc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int IN      = 400,
  parameter int LANES   = 4,
  parameter int RELU_EN = 1,
  parameter int ACC_W   = 2*WIDTH + $clog2(IN) + 1
) (
  input logic clk,
  input logic rst_n,
  fc_neuron_stream_if.slave io
);
  localparam int BEATS = beats(IN, LANES);
  localparam int TAIL  = tail(IN, LANES);
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [LANES-1:0] TMASK = {LANES{1'b1}} >> (LANES - TAIL);
  fc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, z_q, z_d, dot, sum;
  logic busy_q, busy_d, last, fire;
  logic [LANES-1:0] mask;
  fc_lane_dot #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) u_dot (
    .x(io.x), .w(io.w), .lane_mask(mask), .dot(dot)
  );
  always_comb begin
    fire = io.in_valid && state_q == ACC;
    last = cnt_q == CW'(BEATS - 1);
    mask = last ? TMASK : '1;
    sum = (cnt_q == '0 ? ACC_W'($signed(io.bias)) : acc_q) + dot;
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    z_d = z_q;
    busy_d = busy_q;
    if (state_q == HOLD) begin
      state_d = io.out_ready ? ACC : HOLD;
    end else if (fire) begin
      acc_d = sum;
      busy_d = !last;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        z_d = (RELU_EN != 0 && sum[ACC_W-1]) ? '0 : sum;
        state_d = HOLD;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q <= '0;
      acc_q <= '0;
      z_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      z_q <= z_d;
      busy_q <= busy_d;
    end
  end
  assign io.in_ready = state_q == ACC;
  assign io.out_valid = state_q == HOLD;
  assign io.z = z_q;
  assign io.busy = busy_q;
endmodule

// File: tb/tb_fc_neuron_stream.sv
// tb_fc_neuron_stream: directed checks of the streaming neuron across several frame geometries
module tb_fc_neuron_stream;
  logic clk = 0, rst_n = 0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;

  fc_neuron_stream_if #(.WIDTH(8), .LANES(4), .ACC_W(21)) ia();
  fc_neuron_stream_if #(.WIDTH(8), .LANES(4), .ACC_W(21)) ib();
  fc_neuron_stream_if #(.WIDTH(8), .LANES(4), .ACC_W(26)) ic();
  fc_neuron_stream_if #(.WIDTH(8), .LANES(1), .ACC_W(17)) id();
  fc_neuron_stream_if #(.WIDTH(8), .LANES(8), .ACC_W(20)) ie();

  assign ib.in_valid = ia.in_valid;
  assign ib.x = ia.x;
  assign ib.w = ia.w;
  assign ib.bias = ia.bias;
  assign ib.out_ready = ia.out_ready;

  fc_neuron_stream #(.WIDTH(8), .IN(10), .LANES(4), .RELU_EN(1)) ua(.clk(clk), .rst_n(rst_n), .io(ia));
  fc_neuron_stream #(.WIDTH(8), .IN(10), .LANES(4), .RELU_EN(0)) ub(.clk(clk), .rst_n(rst_n), .io(ib));
  fc_neuron_stream #(.WIDTH(8), .IN(400), .LANES(4), .RELU_EN(1)) uc(.clk(clk), .rst_n(rst_n), .io(ic));
  fc_neuron_stream #(.WIDTH(8), .IN(1), .LANES(1), .RELU_EN(1)) ud(.clk(clk), .rst_n(rst_n), .io(id));
  fc_neuron_stream #(.WIDTH(8), .IN(8), .LANES(8), .RELU_EN(1)) ue(.clk(clk), .rst_n(rst_n), .io(ie));

  function automatic logic [31:0] r4(logic [7:0] v);
    return {4{v}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // three beats on the IN=10 instances; lanes 2..3 of the last beat carry garbage that must be masked
  task automatic run_a(input logic [7:0] xv, input logic [7:0] wv, input logic [15:0] b);
    ia.bias = b;
    ia.in_valid = 1;
    ia.x = r4(xv);
    ia.w = r4(wv);
    tick;
    tick;
    ia.x = {8'd127, 8'd127, xv, xv};
    ia.w = {8'd127, 8'd127, wv, wv};
    tick;
    ia.in_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick;
    tick;
    checks++; if (ia.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", ia.in_ready); end
    checks++; if (ia.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", ia.out_valid); end
    checks++; if (ia.z !== 21'd0) begin errs++; $display("FAIL reset_z got %0d want 0", ia.z); end
    checks++; if (ia.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", ia.busy); end
    checks++; if (ic.out_valid !== 1'b0 || ic.z !== 26'd0) begin errs++; $display("FAIL reset_c got ov=%b z=%0d want 0/0", ic.out_valid, ic.z); end
    rst_n = 1;
    tick;
  endtask

  task automatic test_single_frame;
    ia.out_ready = 1;
    ia.bias = 5;
    ia.in_valid = 1;
    ia.x = r4(1);
    ia.w = r4(2);
    tick;
    checks++; if (ia.busy !== 1'b1) begin errs++; $display("FAIL single_busy got %b want 1", ia.busy); end
    tick;
    checks++; if (ia.out_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid got %b want 0", ia.out_valid); end
    ia.x = {8'd127, 8'd127, 8'd1, 8'd1};
    ia.w = {8'd127, 8'd127, 8'd2, 8'd2};
    tick;
    ia.in_valid = 0;
    checks++; if (ia.out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", ia.out_valid); end
    checks++; if (ia.z !== 21'd25) begin errs++; $display("FAIL single_z got %0d want 25", ia.z); end
    checks++; if (ia.busy !== 1'b0 || ia.in_ready !== 1'b0) begin errs++; $display("FAIL single_hold got busy=%b rdy=%b want 0/0", ia.busy, ia.in_ready); end
    tick;
    checks++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin errs++; $display("FAIL single_release got ov=%b rdy=%b want 0/1", ia.out_valid, ia.in_ready); end
  endtask

  task automatic test_relu;
    ia.out_ready = 1;
    run_a(8'd1, 8'hFE, 16'd0);
    checks++; if (ia.z !== 21'd0) begin errs++; $display("FAIL relu_on_z got %0d want 0", ia.z); end
    checks++; if (ib.out_valid !== 1'b1 || ib.z !== 21'h1FFFEC) begin errs++; $display("FAIL relu_off_z got ov=%b z=%h want 1/1fffec", ib.out_valid, ib.z); end
    tick;
  endtask

  task automatic test_backpressure;
    ia.out_ready = 0;
    run_a(8'd1, 8'd2, 16'd5);
    checks++; if (ia.out_valid !== 1'b1 || ia.z !== 21'd25) begin errs++; $display("FAIL bp_first got ov=%b z=%0d want 1/25", ia.out_valid, ia.z); end
    for (int c = 0; c < 5; c++) begin
      ia.in_valid = 1;
      ia.x = r4(9);
      ia.w = r4(9);
      ia.bias = 100;
      tick;
      checks++; if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1 || ia.z !== 21'd25 || ia.busy !== 1'b0) begin errs++; $display("FAIL bp_hold cycle %0d got rdy=%b ov=%b z=%0d busy=%b want 0/1/25/0", c, ia.in_ready, ia.out_valid, ia.z, ia.busy); end
    end
    ia.in_valid = 0;
    ia.out_ready = 1;
    tick;
    checks++; if (ia.out_valid !== 1'b0) begin errs++; $display("FAIL bp_release got %b want 0", ia.out_valid); end
    run_a(8'd1, 8'd1, 16'd2);
    checks++; if (ia.out_valid !== 1'b1 || ia.z !== 21'd12) begin errs++; $display("FAIL bp_next got ov=%b z=%0d want 1/12", ia.out_valid, ia.z); end
    tick;
  endtask

  task automatic test_midframe_reset;
    ia.in_valid = 1;
    ia.x = r4(9);
    ia.w = r4(9);
    ia.bias = 50;
    tick;
    tick;
    ia.in_valid = 0;
    rst_n = 0;
    tick;
    rst_n = 1;
    checks++; if (ia.busy !== 1'b0 || ia.in_ready !== 1'b1 || ia.z !== 21'd0) begin errs++; $display("FAIL mid_reset got busy=%b rdy=%b z=%0d want 0/1/0", ia.busy, ia.in_ready, ia.z); end
    ia.bias = 0;
    ia.x = r4(3);
    ia.w = r4(1);
    ia.in_valid = 1;
    tick;
    ia.in_valid = 0;
    tick;
    tick;
    checks++; if (ia.busy !== 1'b1 || ia.out_valid !== 1'b0) begin errs++; $display("FAIL mid_stall got busy=%b ov=%b want 1/0", ia.busy, ia.out_valid); end
    ia.in_valid = 1;
    tick;
    ia.in_valid = 0;
    tick;
    ia.in_valid = 1;
    tick;
    ia.in_valid = 0;
    checks++; if (ia.out_valid !== 1'b1 || ia.z !== 21'd30) begin errs++; $display("FAIL mid_z got ov=%b z=%0d want 1/30", ia.out_valid, ia.z); end
    checks++; if (ib.z !== 21'd30) begin errs++; $display("FAIL mid_z_norelu got %0d want 30", ib.z); end
    tick;
  endtask

  task automatic test_extreme;
    ic.in_valid = 1;
    ic.x = r4(8'h80);
    ic.w = r4(8'h80);
    ic.bias = 16'sd32767;
    repeat (99) tick;
    checks++; if (ic.out_valid !== 1'b0 || ic.busy !== 1'b1) begin errs++; $display("FAIL ext_partial got ov=%b busy=%b want 0/1", ic.out_valid, ic.busy); end
    tick;
    ic.in_valid = 0;
    checks++; if (ic.out_valid !== 1'b1 || ic.z !== 26'd6586367) begin errs++; $display("FAIL ext_z got ov=%b z=%0d want 1/6586367", ic.out_valid, ic.z); end
    tick;
  endtask

  task automatic test_degenerate;
    id.in_valid = 1;
    id.x = 8'hF9;
    id.w = 8'd3;
    id.bias = 16'd1;
    tick;
    id.in_valid = 0;
    checks++; if (id.out_valid !== 1'b1 || id.z !== 17'd0) begin errs++; $display("FAIL deg_neg got ov=%b z=%0d want 1/0", id.out_valid, id.z); end
    tick;
    checks++; if (id.out_valid !== 1'b0) begin errs++; $display("FAIL deg_release got %b want 0", id.out_valid); end
    id.in_valid = 1;
    id.x = 8'd7;
    tick;
    id.in_valid = 0;
    checks++; if (id.out_valid !== 1'b1 || id.z !== 17'd22) begin errs++; $display("FAIL deg_pos got ov=%b z=%0d want 1/22", id.out_valid, id.z); end
    tick;
  endtask

  task automatic test_back_to_back;
    ie.x = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    ie.w = {8{8'd2}};
    ie.bias = 16'hFFFD;
    ie.in_valid = 1;
    tick;
    checks++; if (ie.out_valid !== 1'b1 || ie.z !== 20'd69) begin errs++; $display("FAIL b2b_first got ov=%b z=%0d want 1/69", ie.out_valid, ie.z); end
    ie.bias = 16'hFFCE;
    tick;
    checks++; if (ie.out_valid !== 1'b0 || ie.in_ready !== 1'b1 || ie.z !== 20'd69) begin errs++; $display("FAIL b2b_gap got ov=%b rdy=%b z=%0d want 0/1/69", ie.out_valid, ie.in_ready, ie.z); end
    tick;
    checks++; if (ie.out_valid !== 1'b1 || ie.z !== 20'd22) begin errs++; $display("FAIL b2b_second got ov=%b z=%0d want 1/22", ie.out_valid, ie.z); end
    ie.bias = 16'hFF9C;
    tick;
    tick;
    ie.in_valid = 0;
    checks++; if (ie.out_valid !== 1'b1 || ie.z !== 20'd0) begin errs++; $display("FAIL b2b_third got ov=%b z=%0d want 1/0", ie.out_valid, ie.z); end
    tick;
  endtask

  initial begin
    ia.in_valid = 0; ia.x = '0; ia.w = '0; ia.bias = '0; ia.out_ready = 1;
    ic.in_valid = 0; ic.x = '0; ic.w = '0; ic.bias = '0; ic.out_ready = 1;
    id.in_valid = 0; id.x = '0; id.w = '0; id.bias = '0; id.out_ready = 1;
    ie.in_valid = 0; ie.x = '0; ie.w = '0; ie.bias = '0; ie.out_ready = 1;
    test_reset;
    test_single_frame;
    test_relu;
    test_backpressure;
    test_midframe_reset;
    test_extreme;
    test_degenerate;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
